smi_rx_scheduler: RTL and testbench

// - Shares the SMI read path between the two RX I/Q FIFOs (0.9 GHz "09", 2.4 GHz "24").
// - Pulls 32-bit words round-robin in bursts, serialises each word MSB-first into bytes for smi_ctrl.
// - Tracks per-channel overflow. Sits between the complex_fifo read ports and smi_ctrl, in the i_sys_clk domain.

---
 rtl/smi_rx_scheduler_pkg.sv | 16 +
 rtl/smi_word_serializer.sv | 61 ++++++
 rtl/smi_rx_scheduler.sv | 126 ++++++++++++
 tb/tb_smi_rx_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/smi_rx_scheduler_pkg.sv
// Shared encodings for the SMI RX scheduler: FSM states and channel identifiers.
package smi_rx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULL  = 2'd1,
    ST_LATCH = 2'd2,
    ST_SHIFT = 2'd3
  } state_e;

  typedef enum logic {
    CH_09 = 1'b0,
    CH_24 = 1'b1
  } ch_e;

endpackage

// File: rtl/smi_word_serializer.sv
// Serialises one 32-bit word MSB-first into four bytes under a valid/ready handshake.
module smi_word_serializer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic        ch_i,
  input  logic        ready_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        ch_o,
  output logic        sow_o,
  output logic        done_o
);

  logic [31:0] sreg_q, sreg_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        ch_q, ch_d;
  logic        accept;

  assign accept = valid_q & ready_i;
  assign done_o = accept & (idx_q == 2'd3);

  always_comb begin
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    if (load_i) begin
      sreg_d  = data_i;
      idx_d   = '0;
      valid_d = 1'b1;
      ch_d    = ch_i;
    end else if (accept) begin
      sreg_d = {sreg_q[23:0], 8'h00};
      idx_d  = 2'(idx_q + 2'd1);
      if (idx_q == 2'd3) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ch_q    <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
    end
  end

  assign byte_o  = sreg_q[31:24];
  assign valid_o = valid_q;
  assign ch_o    = ch_q;
  assign sow_o   = valid_q & (idx_q == 2'd0);

endmodule

// File: rtl/smi_rx_scheduler.sv
// Round-robin burst arbiter between the 09 and 24 RX FIFOs feeding a byte stream to smi_ctrl.
module smi_rx_scheduler
  import smi_rx_scheduler_pkg::*;
#(
  parameter int unsigned BURST_WORDS = 4
) (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_ch_enable,
  input  logic        i_clear_ovf,
  output logic        o_fifo_09_pull,
  input  logic [31:0] i_fifo_09_data,
  input  logic        i_fifo_09_empty,
  input  logic        i_fifo_09_full,
  output logic        o_fifo_24_pull,
  input  logic [31:0] i_fifo_24_data,
  input  logic        i_fifo_24_empty,
  input  logic        i_fifo_24_full,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_byte_ch,
  output logic        o_byte_sow,
  output logic        o_ovf_09,
  output logic        o_ovf_24,
  output logic        o_busy
);

  state_e      state_q, state_d;
  ch_e         sel_q, sel_d;
  ch_e         rr_last_q, rr_last_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        ovf_09_q, ovf_09_d;
  logic        ovf_24_q, ovf_24_d;
  logic        elig_09, elig_24, sel_elig;
  logic [8:0]  burst_next;
  logic        load, word_done;
  logic [31:0] sel_data;

  assign elig_09    = i_ch_enable[0] & ~i_fifo_09_empty;
  assign elig_24    = i_ch_enable[1] & ~i_fifo_24_empty;
  assign sel_elig   = (sel_q == CH_09) ? elig_09 : elig_24;
  assign burst_next = {1'b0, burst_cnt_q} + 9'd1;
  assign sel_data   = (sel_q == CH_09) ? i_fifo_09_data : i_fifo_24_data;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    load        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (elig_09 || elig_24) begin
          if (elig_09 && elig_24) sel_d = (rr_last_q == CH_09) ? CH_24 : CH_09;
          else                    sel_d = elig_09 ? CH_09 : CH_24;
          burst_cnt_d = '0;
          state_d     = ST_PULL;
        end
      end
      ST_PULL:  state_d = ST_LATCH;
      ST_LATCH: begin
        load    = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (word_done) begin
          burst_cnt_d = burst_next[7:0];
          // Eligibility is re-sampled here so an enable drop or FIFO drain ends the burst cleanly.
          if (sel_elig && (burst_next < 9'(BURST_WORDS))) begin
            state_d = ST_PULL;
          end else begin
            rr_last_d = sel_q;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set has priority over clear when both occur in one cycle.
  always_comb begin
    ovf_09_d = (i_fifo_09_full & i_ch_enable[0]) | (ovf_09_q & ~i_clear_ovf);
    ovf_24_d = (i_fifo_24_full & i_ch_enable[1]) | (ovf_24_q & ~i_clear_ovf);
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= CH_09;
      rr_last_q   <= CH_24;
      burst_cnt_q <= '0;
      ovf_09_q    <= 1'b0;
      ovf_24_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
      ovf_09_q    <= ovf_09_d;
      ovf_24_q    <= ovf_24_d;
    end
  end

  smi_word_serializer u_ser (
    .clk_i   (i_sys_clk),
    .rst_i   (i_reset),
    .load_i  (load),
    .data_i  (sel_data),
    .ch_i    (sel_q),
    .ready_i (i_byte_ready),
    .byte_o  (o_byte),
    .valid_o (o_byte_valid),
    .ch_o    (o_byte_ch),
    .sow_o   (o_byte_sow),
    .done_o  (word_done)
  );

  assign o_fifo_09_pull = (state_q == ST_PULL) && (sel_q == CH_09);
  assign o_fifo_24_pull = (state_q == ST_PULL) && (sel_q == CH_24);
  assign o_ovf_09       = ovf_09_q;
  assign o_ovf_24       = ovf_24_q;
  assign o_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_smi_rx_scheduler.sv
// Self-checking bench for smi_rx_scheduler: FIFO models, byte scoreboard and round-robin reference.
module tb_smi_rx_scheduler;

  localparam int unsigned BURST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  en = '0;
  logic        clear_ovf = 1'b0;
  logic        pull09, pull24;
  logic [31:0] data09 = '0, data24 = '0;
  logic        empty09 = 1'b1, empty24 = 1'b1;
  logic        full09 = 1'b0, full24 = 1'b0;
  logic [7:0]  byte_o;
  logic        valid, ready = 1'b1, bch, sow;
  logic        ovf09, ovf24, busy;

  always #5 clk = ~clk;

  smi_rx_scheduler #(.BURST_WORDS(BURST)) dut (
    .i_sys_clk(clk), .i_reset(rst), .i_ch_enable(en), .i_clear_ovf(clear_ovf),
    .o_fifo_09_pull(pull09), .i_fifo_09_data(data09), .i_fifo_09_empty(empty09), .i_fifo_09_full(full09),
    .o_fifo_24_pull(pull24), .i_fifo_24_data(data24), .i_fifo_24_empty(empty24), .i_fifo_24_full(full24),
    .o_byte(byte_o), .o_byte_valid(valid), .i_byte_ready(ready), .o_byte_ch(bch), .o_byte_sow(sow),
    .o_ovf_09(ovf09), .o_ovf_24(ovf24), .o_busy(busy)
  );

  int tests = 0, fails = 0;
  int cyc = 0, pulls09 = 0, pulls24 = 0, accepted = 0;
  int ready_mode = 0;
  logic [31:0] q09[$], q24[$];
  logic [9:0]  exp_q[$];
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_bundle = '0;
  logic        seen_pull09 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference scheduling: round-robin between non-empty enabled queues, up to BURST words each turn.
  task automatic push_word(input logic ch, input logic [31:0] w);
    logic [31:0] t;
    for (int b = 0; b < 4; b++) begin
      t = w << (8 * b);
      exp_q.push_back({ch, (b == 0), t[31:24]});
    end
  endtask

  task automatic build_expected(input logic [1:0] e, output int n09, output int n24);
    logic [31:0] c09[$], c24[$];
    logic last, ch, e0, e1;
    int n;
    c09 = q09; c24 = q24; last = 1'b1; n09 = 0; n24 = 0;
    forever begin
      e0 = e[0] && (c09.size() > 0);
      e1 = e[1] && (c24.size() > 0);
      if (!e0 && !e1) break;
      ch = (e0 && e1) ? ~last : (e0 ? 1'b0 : 1'b1);
      n = 0;
      while (n < int'(BURST) && ((ch == 1'b0) ? c09.size() : c24.size()) > 0) begin
        if (ch == 1'b0) begin push_word(1'b0, c09.pop_front()); n09++; end
        else            begin push_word(1'b1, c24.pop_front()); n24++; end
        n++;
      end
      last = ch;
    end
  endtask

  task automatic tick();
    logic p09, p24;
    logic [9:0] e;
    @(negedge clk);
    cyc++;
    if (prev_stall)
      check("stall_hold", {22'd0, valid, bch, sow, byte_o}, {22'd0, 1'b1, prev_bundle});
    p09 = pull09; p24 = pull24;
    if (p09) begin pulls09++; seen_pull09 = 1'b1; check("pull09_nonempty", {31'd0, empty09}, 32'd0); end
    if (p24) begin pulls24++; check("pull24_nonempty", {31'd0, empty24}, 32'd0); end
    if (valid && ready) begin
      accepted++;
      if (exp_q.size() == 0) begin
        check("byte_unexpected", {22'd0, bch, sow, byte_o}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("byte_stream", {22'd0, bch, sow, byte_o}, {22'd0, e});
      end
    end
    prev_stall  = valid && !ready;
    prev_bundle = {bch, sow, byte_o};
    @(posedge clk);
    #1;
    if (p09 && q09.size() > 0) data09 = q09.pop_front();
    if (p24 && q24.size() > 0) data24 = q24.pop_front();
    empty09 = (q09.size() == 0);
    empty24 = (q24.size() == 0);
    case (ready_mode)
      1:       ready = ($urandom_range(0, 3) != 0);
      2:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: ready = 1'b1;
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    q09.delete(); q24.delete(); exp_q.delete();
    empty09 = 1'b1; empty24 = 1'b1; full09 = 1'b0; full24 = 1'b0;
    en = '0; clear_ovf = 1'b0; ready = 1'b1; ready_mode = 0;
    prev_stall = 1'b0; seen_pull09 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pulls09 = 0; pulls24 = 0; accepted = 0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || busy) && k < budget) begin tick(); k++; end
    check("drain_done", {30'd0, (exp_q.size() == 0), busy}, {30'd0, 2'b10});
  endtask

  task automatic load(input int n09, input int n24);
    for (int i = 0; i < n09; i++) q09.push_back($urandom);
    for (int i = 0; i < n24; i++) q24.push_back($urandom);
    empty09 = (q09.size() == 0);
    empty24 = (q24.size() == 0);
  endtask

  initial begin
    int n09, n24, k;

    // Reset state
    rst = 1'b1;
    #1;
    check("reset_outputs", {19'd0, pull09, pull24, byte_o, valid, bch, sow, ovf09, ovf24, busy}, 32'd0);
    do_reset();

    // Single 09 word, check latency and byte order
    q09.push_back(32'h1122_3344); empty09 = 1'b0; en = 2'b11;
    build_expected(en, n09, n24);
    k = 0;
    while (!seen_pull09 && k < 10) begin tick(); k++; end
    check("first_pull_seen", {31'd0, seen_pull09}, 32'd1);
    check("latch_no_valid", {31'd0, valid}, 32'd0);
    tick();
    check("first_byte", {22'd0, valid, sow, byte_o}, {22'd0, 1'b1, 1'b1, 8'h11});
    drain(40);
    check("single_pulls", {pulls09[15:0], pulls24[15:0]}, {16'd1, 16'd0});

    // 6+6 words, burst order 4/4/2/2
    do_reset();
    en = 2'b11; load(6, 6);
    build_expected(en, n09, n24);
    drain(200);
    check("burst_bytes", accepted, 32'd48);
    check("burst_pulls", {pulls09[15:0], pulls24[15:0]}, {16'd6, 16'd6});

    // Ready pattern 1-0-0-1 stalls
    do_reset();
    en = 2'b11; load(1, 3); ready_mode = 2;
    build_expected(en, n09, n24);
    drain(400);
    check("stall_pulls", {pulls09[15:0], pulls24[15:0]}, {16'd1, 16'd3});

    // 09 enable cleared at the second byte of the first word
    do_reset();
    en = 2'b11; load(6, 2);
    push_word(1'b0, q09[0]);
    begin
      logic [31:0] w24[$];
      w24 = q24;
      foreach (w24[i]) push_word(1'b1, w24[i]);
    end
    k = 0;
    while (accepted < 1 && k < 20) begin tick(); k++; end
    en = 2'b10;
    drain(200);
    check("en_clear_pulls", {pulls09[15:0], pulls24[15:0]}, {16'd1, 16'd2});

    // Overflow set/clear priority
    do_reset();
    en = 2'b11;
    full24 = 1'b1; tick(); full24 = 1'b0;
    check("ovf_set", {30'd0, ovf09, ovf24}, 32'd1);
    tick();
    check("ovf_sticky", {30'd0, ovf09, ovf24}, 32'd1);
    full24 = 1'b1; clear_ovf = 1'b1; tick(); full24 = 1'b0; clear_ovf = 1'b0;
    check("ovf_set_wins", {30'd0, ovf09, ovf24}, 32'd1);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    check("ovf_cleared", {30'd0, ovf09, ovf24}, 32'd0);
    en = 2'b10; full09 = 1'b1; tick(); full09 = 1'b0;
    check("ovf09_disabled", {30'd0, ovf09, ovf24}, 32'd0);
    en = 2'b01; full09 = 1'b1; tick(); full09 = 1'b0;
    check("ovf09_set", {30'd0, ovf09, ovf24}, 32'd2);

    // Reset while presenting byte 2
    do_reset();
    en = 2'b11; load(2, 1);
    build_expected(en, n09, n24);
    k = 0;
    while (accepted < 2 && k < 30) begin tick(); k++; end
    rst = 1'b1;
    #1;
    check("midreset_outputs", {19'd0, pull09, pull24, byte_o, valid, bch, sow, ovf09, ovf24, busy}, 32'd0);
    #2 rst = 1'b0;
    exp_q.delete(); prev_stall = 1'b0;
    build_expected(en, n09, n24);
    drain(100);
    check("midreset_restart", {pulls09[15:0], pulls24[15:0]}, {16'd2, 16'd1});

    // Randomised traffic
    for (int r = 0; r < 8; r++) begin
      do_reset();
      en = 2'($urandom_range(1, 3));
      load($urandom_range(0, 9), $urandom_range(0, 9));
      ready_mode = 1;
      build_expected(en, n09, n24);
      drain(1500);
      check("rand_pulls", {pulls09[15:0], pulls24[15:0]}, {n09[15:0], n24[15:0]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
